// File: rtl/ff_excitation_driver.sv
// ff_excitation_driver: derives JK/SR excitation to steer a flip-flop bank to a target word, applies it, then self-checks.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   tgt_valid/tgt_ready        target handshake; ready only in IDLE
//   tgt_data, mode             target word; 0 = JK, 1 = SR (sampled at accept)
//   exc_a/exc_b, exc_valid     registered J/K or S/R, one-cycle valid pulse
//   q                          flip-flop bank state
//   flips, total_flips         bits changed by last transaction, saturating total
//   done, mismatch             completion pulse and result check
module ff_excitation_driver #(
  parameter int WIDTH = 8,
  parameter int DC_POLICY = 0,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tgt_valid,
  output logic                         tgt_ready,
  input  logic [WIDTH-1:0]             tgt_data,
  input  logic                         mode,
  output logic [WIDTH-1:0]             exc_a,
  output logic [WIDTH-1:0]             exc_b,
  output logic                         exc_valid,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(WIDTH+1)-1:0]   flips,
  output logic [CNT_W-1:0]             total_flips,
  output logic                         done,
  output logic                         mismatch
);
  localparam int FW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, tgt_q, tgt_d, exc_a_q, exc_a_d, exc_b_q, exc_b_d;
  logic [WIDTH-1:0] xm, diff, jk_a, jk_b, sr_a, sr_b, jk_q, sr_q;
  logic mode_q, mode_d, exc_valid_q, exc_valid_d, done_q, done_d, mismatch_q, mismatch_d, accept;
  logic [FW-1:0] flips_q, flips_d, pc;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W:0] sum;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (tgt_valid ? DRIVE : IDLE) : state_q == DRIVE ? CHECK : IDLE;
  always_comb begin
    tgt_ready = state_q == IDLE;
    accept = tgt_ready & tgt_valid;
  end
  // don't-care excitation entries take DC_POLICY; the SR form keeps S and R disjoint either way
  always_comb begin
    xm = DC_POLICY != 0 ? '1 : '0;
    diff = q_q ^ tgt_data;
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + FW'(diff[i]);
    sum = {1'b0, total_q} + (CNT_W+1)'(pc);
    jk_a = (q_q & xm) | (~q_q & tgt_data);
    jk_b = (q_q & ~tgt_data) | (~q_q & xm);
    sr_a = tgt_data & (~q_q | xm);
    sr_b = ~tgt_data & (q_q | xm);
    jk_q = (exc_a_q & ~q_q) | (~exc_b_q & q_q);
    sr_q = (exc_a_q & ~exc_b_q) | (q_q & (exc_a_q | ~exc_b_q));
    q_d = state_q == DRIVE ? (mode_q ? sr_q : jk_q) : q_q;
    tgt_d = accept ? tgt_data : tgt_q;
    mode_d = accept ? mode : mode_q;
    exc_a_d = accept ? (mode ? sr_a : jk_a) : exc_a_q;
    exc_b_d = accept ? (mode ? sr_b : jk_b) : exc_b_q;
    exc_valid_d = accept;
    flips_d = accept ? pc : flips_q;
    total_d = accept ? (sum[CNT_W] ? '1 : sum[CNT_W-1:0]) : total_q;
    done_d = state_q == CHECK;
    mismatch_d = state_q == CHECK && q_q != tgt_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      q_q <= '0;
      tgt_q <= '0;
      mode_q <= 1'b0;
      exc_a_q <= '0;
      exc_b_q <= '0;
      exc_valid_q <= 1'b0;
      flips_q <= '0;
      total_q <= '0;
      done_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      q_q <= q_d;
      tgt_q <= tgt_d;
      mode_q <= mode_d;
      exc_a_q <= exc_a_d;
      exc_b_q <= exc_b_d;
      exc_valid_q <= exc_valid_d;
      flips_q <= flips_d;
      total_q <= total_d;
      done_q <= done_d;
      mismatch_q <= mismatch_d;
    end
  assign q = q_q;
  assign exc_a = exc_a_q;
  assign exc_b = exc_b_q;
  assign exc_valid = exc_valid_q;
  assign flips = flips_q;
  assign total_flips = total_q;
  assign done = done_q;
  assign mismatch = mismatch_q;
endmodule

// File: tb/tb_ff_excitation_driver.sv
// tb_ff_excitation_driver: directed checks of two driver instances (DC_POLICY 0 / wide counter, DC_POLICY 1 / 4-bit counter).
module tb_ff_excitation_driver;
  logic clk = 0, rst = 1, tgt_valid = 0, mode = 0;
  logic [7:0] tgt_data = 0;
  logic rdy0, rdy1, ev0, ev1, dn0, dn1, mm0, mm1;
  logic [7:0] a0, b0, a1, b1, q0, q1;
  logic [3:0] fl0, fl1, tot1;
  logic [15:0] tot0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  ff_excitation_driver #(.WIDTH(8), .DC_POLICY(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy0), .tgt_data(tgt_data), .mode(mode),
    .exc_a(a0), .exc_b(b0), .exc_valid(ev0), .q(q0), .flips(fl0), .total_flips(tot0),
    .done(dn0), .mismatch(mm0));
  ff_excitation_driver #(.WIDTH(8), .DC_POLICY(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy1), .tgt_data(tgt_data), .mode(mode),
    .exc_a(a1), .exc_b(b1), .exc_valid(ev1), .q(q1), .flips(fl1), .total_flips(tot1),
    .done(dn1), .mismatch(mm1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input logic [7:0] d, input logic m, input logic [7:0] ea0, input logic [7:0] eb0,
                      input logic [7:0] ea1, input logic [7:0] eb1, input logic [3:0] fl,
                      input logic [15:0] t0, input logic [3:0] t1);
    chk("ready_before", {rdy0, rdy1}, 2'b11);
    tgt_valid = 1;
    tgt_data = d;
    mode = m;
    step();
    tgt_valid = 0;
    tgt_data = 8'($urandom);
    mode = 1'($urandom);
    chk("exc_a0", a0, ea0);
    chk("exc_b0", b0, eb0);
    chk("exc_a1", a1, ea1);
    chk("exc_b1", b1, eb1);
    chk("exc_valid", {ev0, ev1}, 2'b11);
    chk("flips", {fl0, fl1}, {fl, fl});
    chk("total0", tot0, t0);
    chk("total1", tot1, t1);
    chk("ready_drive", {rdy0, rdy1}, 2'b00);
    if (m) chk("sr_disjoint", (a0 & b0) | (a1 & b1), 8'h00);
    step();
    chk("q_after_e1", {q0, q1}, {d, d});
    chk("exc_valid_low", {ev0, ev1}, 2'b00);
    chk("exc_hold", {a0, b0}, {ea0, eb0});
    chk("done_early", {dn0, dn1}, 2'b00);
    step();
    chk("done", {dn0, dn1}, 2'b11);
    chk("mismatch", {mm0, mm1}, 2'b00);
  endtask
  initial begin
    logic [7:0] last;
    int ph, nacc, ndone;
    step();
    step();
    rst = 0;
    chk("rst_q", {q0, q1}, 16'h0);
    chk("rst_ready", {rdy0, rdy1}, 2'b11);
    chk("rst_done", {dn0, dn1}, 2'b00);
    chk("rst_total", {tot0, tot1}, 20'h0);
    chk("rst_exc", {a0, b0, a1, b1, ev0, ev1}, 34'h0);
    step();
    chk("idle_q", {q0, q1}, 16'h0);
    xact(8'hA5, 0, 8'hA5, 8'h00, 8'hA5, 8'hFF, 4, 16'd4, 4'd4);
    xact(8'h3C, 0, 8'h18, 8'h81, 8'hBD, 8'hDB, 4, 16'd8, 4'd8);
    xact(8'hC3, 1, 8'hC3, 8'h3C, 8'hC3, 8'h3C, 8, 16'd16, 4'd15);
    xact(8'hC3, 1, 8'h00, 8'h00, 8'hC3, 8'h3C, 0, 16'd16, 4'd15);
    step();
    chk("done_pulse_end", {dn0, dn1, mm0, mm1}, 4'b0000);
    // backpressure: valid held high with fresh data every cycle
    mode = 0;
    tgt_valid = 1;
    ph = 0;
    nacc = 0;
    ndone = 0;
    last = 0;
    for (int c = 0; c < 12; c++) begin
      tgt_data = 8'($urandom);
      chk("bp_ready", rdy0, ph == 0);
      if (ph == 0) begin
        last = tgt_data;
        nacc++;
      end
      step();
      ph = (ph + 1) % 3;
      if (ph == 2) chk("bp_q", q0, last);
      chk("bp_done", dn0, ph == 0);
      if (dn0) ndone++;
    end
    tgt_valid = 0;
    chk("bp_count", ndone, nacc);
    chk("bp_accepts", nacc, 4);
    // reset while in DRIVE
    tgt_valid = 1;
    tgt_data = 8'h5A;
    step();
    tgt_valid = 0;
    rst = 1;
    step();
    chk("mrst_q", {q0, q1}, 16'h0);
    chk("mrst_total", {tot0, tot1}, 20'h0);
    chk("mrst_done", {dn0, dn1}, 2'b00);
    rst = 0;
    step();
    chk("mrst_no_done", {dn0, dn1, ev0, ev1}, 4'b0000);
    step();
    chk("mrst_no_done2", {dn0, dn1, q0}, 10'h0);
    xact(8'hFF, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8, 16'd8, 4'd8);
    xact(8'h00, 0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8, 16'd16, 4'd15);
    xact(8'hFF, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8, 16'd24, 4'd15);
    step();
    chk("sat_hold", tot1, 4'd15);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ff_excitation_driver.md
Name: ff_excitation_driver

Overview:
- Excitation-side counterpart to the characteristic-equation flip-flop cells.
- Accepts a target state word over a valid/ready handshake and derives the per-bit excitation inputs needed to move an internal flip-flop bank from its current state to that target: J/K in JK mode, S/R in SR mode.
- Applies those inputs to the bank through the matching characteristic equation, then self-checks the result.
- Used as the stimulus/steering stage for flip-flop conversion blocks and as a transition counter.

Parameters:
- WIDTH, 8, number of flip-flop bits in the bank.
- DC_POLICY, 0, value used for excitation don't-care entries (0 or 1).
- CNT_W, 16, width of the saturating cumulative flip counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- tgt_valid  input  1  target word valid.
- tgt_ready  output  1  block can accept a target; high only in IDLE.
- tgt_data  input  WIDTH  requested next state of the bank.
- mode  input  1  0 = JK excitation, 1 = SR excitation; sampled at accept.
- exc_a  output  WIDTH  registered J (JK mode) or S (SR mode).
- exc_b  output  WIDTH  registered K (JK mode) or R (SR mode).
- exc_valid  output  1  exc_a/exc_b hold a new excitation; one-cycle pulse.
- q  output  WIDTH  current flip-flop bank state.
- flips  output  $clog2(WIDTH+1)  number of bits changed by the current/last transaction.
- total_flips  output  CNT_W  cumulative changed bits, saturating.
- done  output  1  one-cycle pulse when the transaction completes.
- mismatch  output  1  q differs from target at check; valid with done.

Behaviour:
- Reset: state = IDLE; q = 0; exc_a = exc_b = 0; exc_valid = 0; flips = 0; total_flips = 0; done = 0; mismatch = 0; tgt_ready = 1 on the cycle after reset releases.
- FSM: IDLE -> DRIVE -> CHECK -> IDLE. tgt_ready = (state == IDLE), decoded combinationally.
- Edge E0, IDLE with tgt_valid & tgt_ready:
  - Capture tgt_data into tgt_reg and mode into mode_reg.
  - Register the excitation into exc_a/exc_b; set exc_valid = 1.
  - flips <= popcount(q ^ tgt_data); total_flips <= min(total_flips + that popcount, 2^CNT_W - 1).
  - Go to DRIVE.
- Per-bit excitation (q = current bit, t = target bit, X = DC_POLICY):
  - JK mode: 0->0 gives J=0, K=X. 0->1 gives J=1, K=X. 1->0 gives J=X, K=1. 1->1 gives J=X, K=0.
  - SR mode: 0->0 gives S=0, R=X. 0->1 gives S=1, R=0. 1->0 gives S=0, R=1. 1->1 gives S=X, R=0.
  - The SR table never produces S=R=1 for either DC_POLICY value.
- Edge E1, DRIVE:
  - Update q per bit from exc_a/exc_b using mode_reg's characteristic equation.
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - SR: 00 hold, 01 clear, 10 set, 11 hold (unreachable).
  - exc_valid <= 0; exc_a/exc_b retain their values. Go to CHECK.
- Edge E2, CHECK:
  - done <= 1; mismatch <= (q != tgt_reg). Go to IDLE.
  - done and mismatch are high for exactly the cycle after E2, then return to 0.
- Latency and throughput:
  - Excitation is visible the cycle after accept.
  - New q is visible two cycles after accept; done appears three cycles after accept.
  - One transaction per 3 cycles. A new accept is allowed on the same cycle done is high.
- tgt_valid in DRIVE/CHECK is not accepted. tgt_data may change freely while tgt_ready = 0.
- A transaction with tgt_data == q still runs all three states, with flips = 0 and exc_valid pulsed.
- Reset mid-operation (any state): immediate return to reset values. No done pulse. The pending target is discarded.
- mismatch = 1 indicates an internal fault; correct RTL never asserts it.

Test Plan:
- Reset then idle: assert rst 2 cycles -> q=0x00, tgt_ready=1, done=0, total_flips=0.
- JK, DC_POLICY=0, q=0x00, send 0xA5 -> exc_a=0xA5, exc_b=0x00, flips=4; q=0xA5 after E1; done=1, mismatch=0; total_flips=4.
- JK, DC_POLICY=1, q=0xA5, send 0x3C -> exc_a=0xBD, exc_b=0xDB, flips=4; q=0x3C; total_flips=8.
- SR, DC_POLICY=0, q=0x3C, send 0xC3 -> exc_a=0xC3, exc_b=0x3C; (exc_a & exc_b) is 0 in every transaction; flips=8; q=0xC3.
- Backpressure: hold tgt_valid=1 with data changing every cycle -> accepts only at IDLE cycles, one per 3 cycles; each accepted value equals the data sampled at its accept edge; done count equals accept count.
- Reset in DRIVE, plus saturation with CNT_W=4: assert rst in DRIVE -> q=0, no done, total_flips=0. Then send 0xFF, 0x00, 0xFF -> total_flips saturates at 15 and stays there.
